// File: rtl/vga_rx_pkg.sv
// ----------------------------------------------------------------------------
// vga_rx_pkg
// Shared definitions for the VGA loopback receiver (vga_rx_monitor).
//   - default 640x480@60 timing constants
//   - counter width (coordinates, hcnt/vcnt) and statistics width
//   - FSM state type and encodings (HUNT=0, ALIGN=1, LOCKED=2)
//   - saturating increment helpers for counters and statistics
// ----------------------------------------------------------------------------
package vga_rx_pkg;

    localparam int CNT_W  = 10;
    localparam int STAT_W = 16;

    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_START  = 144;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_START  = 35;
    localparam int DEF_V_ACTIVE = 480;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_HUNT   = 2'd0;
    localparam rx_state_t ST_ALIGN  = 2'd1;
    localparam rx_state_t ST_LOCKED = 2'd2;

    // Position counters stick at their maximum instead of wrapping, so a
    // missing sync edge can never alias back into a valid-looking count.
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc_sat(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/vga_rx_edge.sv
// ----------------------------------------------------------------------------
// vga_rx_edge
// Polarity correction and leading-edge detection for one sync input.
// The previous-value register only advances on pix_ce, so the edge is
// defined between consecutive pixel samples, not board_clk cycles.
//
// Ports:
//   board_clk  in   system clock
//   Reset      in   asynchronous, active-high reset
//   pix_ce     in   pixel sample enable
//   sync_in    in   raw sync pin value
//   lead       out  leading edge of the asserted sync, valid on pix_ce cycles
// Parameters:
//   ACTIVE_LOW 1 = sync asserted low
// ----------------------------------------------------------------------------
module vga_rx_edge
    import vga_rx_pkg::*;
#(
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic pix_ce,
    input  logic sync_in,
    output logic lead
);

    logic act;
    logic prev;

    assign act = ACTIVE_LOW ? ~sync_in : sync_in;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            prev <= 1'b0;
        end else if (pix_ce) begin
            prev <= act;
        end
    end

    // Qualified with pix_ce so the pulse can be consumed without re-gating.
    assign lead = pix_ce & act & ~prev;

endmodule

// File: rtl/vga_rx_monitor.sv
// ----------------------------------------------------------------------------
// vga_rx_monitor
// Loopback receiver for the game's VGA output. Recovers pixel coordinates
// from the h/v syncs, verifies line and frame timing, and reports per-frame
// red and red&green (bird/pipe overlap) pixel counts.
//
// Build option:
//   VGA_RX_COLOR_STATS_EN  defined   -> colour accumulators are built and
//                                       red_cnt/overlap_cnt are reported
//                          undefined -> no accumulators, red_cnt and
//                                       overlap_cnt are tied to 0
//
// Ports:
//   board_clk    in   system clock
//   Reset        in   asynchronous, active-high reset
//   pix_ce       in   pixel sample enable (one cycle per pixel)
//   vga_h_sync   in   horizontal sync
//   vga_v_sync   in   vertical sync
//   vga_r/g/b    in   1-bit pixel colour
//   rx_x, rx_y   out  active-area column/row of the last sample (0 if idle)
//   rx_active    out  last sample was inside the active area while locked
//   locked       out  timing verified
//   frame_done   out  one-cycle pulse per completed locked frame
//   red_cnt      out  red pixels in the last completed frame
//   overlap_cnt  out  red&green pixels in the last completed frame
//   err_cnt      out  timing errors seen while locked, saturating at 255
// ----------------------------------------------------------------------------
module vga_rx_monitor
    import vga_rx_pkg::*;
#(
    parameter int H_TOTAL         = DEF_H_TOTAL,
    parameter int H_START         = DEF_H_START,
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int V_TOTAL         = DEF_V_TOTAL,
    parameter int V_START         = DEF_V_START,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                board_clk,
    input  logic                Reset,
    input  logic                pix_ce,
    input  logic                vga_h_sync,
    input  logic                vga_v_sync,
    input  logic                vga_r,
    input  logic                vga_g,
    input  logic                vga_b,
    output logic [CNT_W-1:0]    rx_x,
    output logic [CNT_W-1:0]    rx_y,
    output logic                rx_active,
    output logic                locked,
    output logic                frame_done,
    output logic [STAT_W-1:0]   red_cnt,
    output logic [STAT_W-1:0]   overlap_cnt,
    output logic [7:0]          err_cnt
);

    localparam int CW1 = CNT_W + 1;

    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W:0]   FRAME_LINES = CW1'(V_TOTAL);
    localparam logic [CNT_W:0]   H_LO = CW1'(H_START);
    localparam logic [CNT_W:0]   H_HI = CW1'(H_START + H_ACTIVE);
    localparam logic [CNT_W:0]   V_LO = CW1'(V_START);
    localparam logic [CNT_W:0]   V_HI = CW1'(V_START + V_ACTIVE);
    localparam logic [CNT_W-1:0] X_OFF = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] Y_OFF = CNT_W'(V_START);

    logic               h_lead;
    logic               v_lead;
    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   vcnt;
    logic [CNT_W-1:0]   hcnt_n;
    logic [CNT_W-1:0]   vcnt_n;
    rx_state_t          state;
    rx_state_t          state_n;
    logic               mismatch;
    logic               mismatch_n;
    logic               line_fail;
    logic               frame_ok;
    logic [CNT_W:0]     frame_lines;
    logic               err_inc;
    logic               publish;
    logic               win_h;
    logic               win_v;
    logic               sample_active;

    vga_rx_edge #(
        .ACTIVE_LOW (SYNC_ACTIVE_LOW != 0)
    ) u_h_edge (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .pix_ce     (pix_ce),
        .sync_in    (vga_h_sync),
        .lead       (h_lead)
    );

    vga_rx_edge #(
        .ACTIVE_LOW (SYNC_ACTIVE_LOW != 0)
    ) u_v_edge (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .pix_ce     (pix_ce),
        .sync_in    (vga_v_sync),
        .lead       (v_lead)
    );

    // Coordinates of the sample being taken now. A v edge wins over a
    // coincident h edge so the first line of a frame is line 0.
    always_comb begin
        hcnt_n = h_lead ? '0 : cnt_inc_sat(hcnt);
        vcnt_n = vcnt;
        if (v_lead) begin
            vcnt_n = '0;
        end else if (h_lead) begin
            vcnt_n = cnt_inc_sat(vcnt);
        end
    end

    // Lines in the frame include an h edge landing on the closing v edge;
    // with aligned syncs that edge is the one that vcnt never counted.
    assign line_fail   = h_lead && (hcnt != LINE_LAST);
    assign frame_lines = {1'b0, vcnt} + {{CNT_W{1'b0}}, h_lead};
    assign frame_ok    = (frame_lines == FRAME_LINES);

    always_comb begin
        state_n    = state;
        mismatch_n = mismatch;
        err_inc    = 1'b0;
        publish    = 1'b0;
        case (state)
            ST_HUNT: begin
                if (v_lead) begin
                    state_n    = ST_ALIGN;
                    mismatch_n = 1'b0;
                end
            end
            ST_ALIGN: begin
                if (v_lead) begin
                    if (!mismatch && !line_fail && frame_ok) begin
                        state_n = ST_LOCKED;
                    end
                    mismatch_n = 1'b0;
                end else if (line_fail) begin
                    mismatch_n = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (line_fail || (v_lead && !frame_ok)) begin
                    state_n = ST_HUNT;
                    err_inc = 1'b1;
                end else if (v_lead) begin
                    publish = 1'b1;
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    // The window is judged with the post-update state, so a sample that
    // breaks lock is already reported as inactive.
    assign win_h = ({1'b0, hcnt_n} >= H_LO) && ({1'b0, hcnt_n} < H_HI);
    assign win_v = ({1'b0, vcnt_n} >= V_LO) && ({1'b0, vcnt_n} < V_HI);
    assign sample_active = pix_ce && (state_n == ST_LOCKED) && win_h && win_v;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            state    <= ST_HUNT;
            mismatch <= 1'b0;
        end else if (pix_ce) begin
            hcnt     <= hcnt_n;
            vcnt     <= vcnt_n;
            state    <= state_n;
            mismatch <= mismatch_n;
        end
    end

    // frame_done is cleared on every board_clk so that it stays a single
    // cycle even when pix_ce is sparse.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            rx_x       <= '0;
            rx_y       <= '0;
            rx_active  <= 1'b0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= '0;
        end else begin
            frame_done <= publish;
            if (pix_ce) begin
                rx_active <= sample_active;
                rx_x      <= sample_active ? (hcnt_n - X_OFF) : '0;
                rx_y      <= sample_active ? (vcnt_n - Y_OFF) : '0;
                locked    <= (state_n == ST_LOCKED);
                if (err_inc && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

`ifdef VGA_RX_COLOR_STATS_EN

    logic [STAT_W-1:0] red_acc;
    logic [STAT_W-1:0] ovl_acc;
    logic              unused_blue;

    assign unused_blue = vga_b;

    // Every v edge starts a fresh frame; the sample taken on it is blanking
    // and is never counted. Totals are only published on a clean frame.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            red_acc     <= '0;
            ovl_acc     <= '0;
            red_cnt     <= '0;
            overlap_cnt <= '0;
        end else if (pix_ce) begin
            if (v_lead) begin
                red_acc <= '0;
                ovl_acc <= '0;
                if (publish) begin
                    red_cnt     <= red_acc;
                    overlap_cnt <= ovl_acc;
                end
            end else if (sample_active) begin
                if (vga_r) begin
                    red_acc <= stat_inc_sat(red_acc);
                end
                if (vga_r && vga_g) begin
                    ovl_acc <= stat_inc_sat(ovl_acc);
                end
            end
        end
    end

`else

    logic unused_colour;

    assign unused_colour = vga_r ^ vga_g ^ vga_b;
    assign red_cnt       = '0;
    assign overlap_cnt   = '0;

`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// ----------------------------------------------------------------------------
// tb_vga_rx_monitor
// Drives a reduced 16x10 timing (8x4 active) through vga_rx_monitor with
// directed frames: clean frames, a short line, a long frame and a mid-frame
// reset. Expected pixels and frame results are queued by the stimulus and
// checked by independent monitors. The whole sequence runs with pix_ce every
// cycle and again with pix_ce every 4th cycle.
// ----------------------------------------------------------------------------
module tb_vga_rx_monitor;

    localparam int H_TOTAL  = 16;
    localparam int H_START  = 4;
    localparam int H_ACTIVE = 8;
    localparam int V_TOTAL  = 10;
    localparam int V_START  = 2;
    localparam int V_ACTIVE = 4;

`ifdef VGA_RX_COLOR_STATS_EN
    localparam logic [15:0] EXP_RED = 16'd6;
    localparam logic [15:0] EXP_OVL = 16'd2;
`else
    localparam logic [15:0] EXP_RED = 16'd0;
    localparam logic [15:0] EXP_OVL = 16'd0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pix_t;

    typedef struct packed {
        logic [15:0] red;
        logic [15:0] ovl;
        logic [7:0]  err;
    } done_t;

    logic        board_clk  = 1'b0;
    logic        Reset      = 1'b0;
    logic        pix_ce     = 1'b0;
    logic        vga_h_sync = 1'b1;
    logic        vga_v_sync = 1'b1;
    logic        vga_r      = 1'b0;
    logic        vga_g      = 1'b0;
    logic        vga_b      = 1'b0;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic        rx_active;
    logic        locked;
    logic        frame_done;
    logic [15:0] red_cnt;
    logic [15:0] overlap_cnt;
    logic [7:0]  err_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    ce_div   = 1;
    int    exp_err  = 0;
    logic  ce_q     = 1'b0;
    pix_t  pix_q[$];
    done_t done_q[$];
    pix_t  pix_got;
    done_t done_got;

    vga_rx_monitor #(
        .H_TOTAL         (H_TOTAL),
        .H_START         (H_START),
        .H_ACTIVE        (H_ACTIVE),
        .V_TOTAL         (V_TOTAL),
        .V_START         (V_START),
        .V_ACTIVE        (V_ACTIVE),
        .SYNC_ACTIVE_LOW (1)
    ) dut (
        .board_clk   (board_clk),
        .Reset       (Reset),
        .pix_ce      (pix_ce),
        .vga_h_sync  (vga_h_sync),
        .vga_v_sync  (vga_v_sync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .rx_x        (rx_x),
        .rx_y        (rx_y),
        .rx_active   (rx_active),
        .locked      (locked),
        .frame_done  (frame_done),
        .red_cnt     (red_cnt),
        .overlap_cnt (overlap_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 board_clk = ~board_clk;

    always @(posedge board_clk) ce_q <= pix_ce;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pixel monitor: one decision per pix_ce sample, half a clock after the
    // registered outputs updated.
    always @(negedge board_clk) begin
        if (ce_q) begin
            if (rx_active) begin
                if (pix_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL pixel_unexpected: got rx_active at x=%0d y=%0d, expected idle",
                             rx_x, rx_y);
                end else begin
                    pix_got = pix_q.pop_front();
                    checkOutput("pixel_x", 32'(rx_x), 32'(pix_got.x));
                    checkOutput("pixel_y", 32'(rx_y), 32'(pix_got.y));
                end
            end else begin
                checkOutput("idle_xy", 32'({rx_x, rx_y}), 32'd0);
            end
        end
    end

    // Frame monitor: every frame_done cycle must match a queued frame result.
    always @(negedge board_clk) begin
        if (frame_done) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL frame_done_unexpected: got pulse, expected none");
            end else begin
                done_got = done_q.pop_front();
                checkOutput("done_red_cnt", 32'(red_cnt), 32'(done_got.red));
                checkOutput("done_overlap_cnt", 32'(overlap_cnt), 32'(done_got.ovl));
                checkOutput("done_err_cnt", 32'(err_cnt), 32'(done_got.err));
                checkOutput("done_locked", 32'(locked), 32'd1);
            end
        end
    end

    // One pixel sample; syncs are given as asserted flags and driven low.
    task automatic applyStimulus(input logic hs, input logic vs,
                                 input logic r, input logic g);
        vga_h_sync = ~hs;
        vga_v_sync = ~vs;
        vga_r      = r;
        vga_g      = g;
        pix_ce     = 1'b1;
        @(posedge board_clk);
        #1;
        pix_ce = 1'b0;
        for (int i = 1; i < ce_div; i++) begin
            @(posedge board_clk);
            #1;
        end
    endtask

    task automatic applyReset();
        vga_h_sync = 1'b1;
        vga_v_sync = 1'b1;
        pix_ce     = 1'b0;
        Reset      = 1'b1;
        repeat (3) @(posedge board_clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic midFrameReset(input string tag);
        @(negedge board_clk);
        #1;
        Reset = 1'b1;
        #1;
        checkOutput({tag, " rst_xy_active"}, 32'({rx_x, rx_y, rx_active}), 32'd0);
        checkOutput({tag, " rst_locked_done"}, 32'({locked, frame_done}), 32'd0);
        checkOutput({tag, " rst_err_cnt"}, 32'(err_cnt), 32'd0);
        checkOutput({tag, " rst_stats"}, {red_cnt, overlap_cnt}, 32'd0);
        @(posedge board_clk);
        #1;
        Reset = 1'b0;
    endtask

    // One frame of n_lines lines; v and h syncs are asserted for the first
    // two lines/pixels so the v edge lands on an h edge. Red and green are
    // driven everywhere in blanking so any window error shows in the counts.
    task automatic sendFrame(input string tag, input int n_lines,
                             input int short_line, input int rst_line,
                             input logic lock_first, input logic frame_locked,
                             input logic done_after);
        int   len;
        int   ax;
        int   ay;
        logic in_area;
        logic r;
        logic g;
        logic live;
        live = frame_locked;
        for (int ln = 0; ln < n_lines; ln++) begin
            len = (ln == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int hc = 0; hc < len; hc++) begin
                ax = hc - H_START;
                ay = ln - V_START;
                in_area = (ax >= 0) && (ax < H_ACTIVE) && (ay >= 0) && (ay < V_ACTIVE);
                r = in_area ? ((ax >= 1) && (ax <= 3) && (ay >= 1) && (ay <= 2)) : 1'b1;
                g = in_area ? ((ax >= 3) && (ax <= 4) && (ay >= 1) && (ay <= 2)) : 1'b1;
                if ((ln == rst_line) && (hc == 6)) begin
                    midFrameReset(tag);
                    live    = 1'b0;
                    exp_err = 0;
                end
                if (live && in_area) begin
                    pix_q.push_back('{x: 10'(ax), y: 10'(ay)});
                end
                applyStimulus(hc < 2, ln < 2, r, g);
                if ((ln == 0) && (hc == 0)) begin
                    checkOutput({tag, " locked_at_vedge"}, 32'(locked), 32'(lock_first));
                    checkOutput({tag, " err_cnt_at_vedge"}, 32'(err_cnt), 32'(exp_err));
                end
                if ((ln == 0) && (hc == 1)) begin
                    checkOutput({tag, " frame_done_pending"}, 32'(done_q.size()), 32'd0);
                end
                if ((short_line >= 0) && (ln == short_line + 1) && (hc == 0)) begin
                    exp_err++;
                    checkOutput({tag, " err_cnt_after_short"}, 32'(err_cnt), 32'(exp_err));
                    checkOutput({tag, " locked_after_short"}, 32'(locked), 32'd0);
                end
            end
            if (ln == short_line) begin
                live = 1'b0;
            end
        end
        if (done_after) begin
            done_q.push_back('{red: EXP_RED, ovl: EXP_OVL, err: 8'(exp_err)});
        end
    endtask

    task automatic runScenario(input int div);
        ce_div  = div;
        exp_err = 0;
        pix_q.delete();
        done_q.delete();
        applyReset();
        checkOutput("reset_xy_active", 32'({rx_x, rx_y, rx_active}), 32'd0);
        checkOutput("reset_locked_done", 32'({locked, frame_done}), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("reset_stats", {red_cnt, overlap_cnt}, 32'd0);

        sendFrame("F1",  10, -1, -1, 1'b0, 1'b0, 1'b0);
        sendFrame("F2",  10, -1, -1, 1'b1, 1'b1, 1'b1);
        sendFrame("F3",  10, -1, -1, 1'b1, 1'b1, 1'b1);
        sendFrame("F4",  10,  7, -1, 1'b1, 1'b1, 1'b0);
        sendFrame("F5",  10, -1, -1, 1'b0, 1'b0, 1'b0);
        sendFrame("F6",  10, -1, -1, 1'b1, 1'b1, 1'b1);
        sendFrame("F7",  11, -1, -1, 1'b1, 1'b1, 1'b0);
        exp_err++;
        sendFrame("F8",  10, -1, -1, 1'b0, 1'b0, 1'b0);
        sendFrame("F9",  10, -1, -1, 1'b0, 1'b0, 1'b0);
        sendFrame("F10", 10, -1, -1, 1'b1, 1'b1, 1'b1);
        sendFrame("F11", 10, -1,  3, 1'b1, 1'b1, 1'b0);
        sendFrame("F12", 10, -1, -1, 1'b0, 1'b0, 1'b0);
        sendFrame("F13", 10, -1, -1, 1'b1, 1'b1, 1'b1);
        sendFrame("F14", 10, -1, -1, 1'b1, 1'b1, 1'b0);

        repeat (4 * div) @(posedge board_clk);
        #1;
        checkOutput("pixels_outstanding", 32'(pix_q.size()), 32'd0);
        checkOutput("frames_outstanding", 32'(done_q.size()), 32'd0);
    endtask

    initial begin
        $display("[TB] pix_ce every cycle");
        runScenario(1);
        $display("[TB] pix_ce every 4th cycle");
        runScenario(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
